// File: rtl/me_pkg.sv
// Shared constants and FSM state type for the motion-estimation current-block load path.
// Word geometry: two pixels per buffer word, 16 words per 32-pixel row, 512 words per block.
package me_pkg;
   localparam int PIXEL         = 8;
   localparam int BLK_DIM       = 32;
   localparam int WORDS_PER_ROW = BLK_DIM / 2;
   localparam int WORDS_PER_BLK = BLK_DIM * BLK_DIM / 2;
   localparam int CB_W          = 3;
   localparam int IDX_W         = $clog2(WORDS_PER_BLK);
   localparam int ADDR_W        = CB_W + IDX_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2,
      SWAP  = 2'd3
   } state_t;
endpackage

// File: rtl/curr_blk_feeder.sv
// Streams one 32x32 current block from the buffer to the PE array, 2 pixels/clk, then pulses change_curr.
// Latency: first pair 2 cycles after start, swap pulse 514 cycles after start with no hold.
// Backpressure: hold blocks new reads only; issued reads always emit. Optional CURR_BLK_FEEDER_STALL_CNT_EN adds stall_cnt.
module curr_blk_feeder
   import me_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [CB_W-1:0]     cb_id,
   input  logic                hold,
   output logic                mem_rd_en,
   output logic [ADDR_W-1:0]   mem_addr,
   input  logic [2*PIXEL-1:0]  mem_rd_data,
   output logic [2*PIXEL-1:0]  current_2pixels,
   output logic                in_curr_enable,
   output logic [CB_W-1:0]     CB_select,
   output logic                change_curr,
   output logic                busy,
`ifdef CURR_BLK_FEEDER_STALL_CNT_EN
   output logic [15:0]         stall_cnt,
`endif
   output logic                done
);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CB_W-1:0]    r_cb_q;
   logic [IDX_W-1:0]   r_word_idx;
   logic               r_rd_d;
   logic [2*PIXEL-1:0] r_pix;
   logic               w_accept;
   logic               w_rd;
   logic               w_last_rd;

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_rd        = 1'b0;
      w_last_rd   = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_accept    = 1'b1;
               w_state_nxt = FETCH;
            end
         end
         FETCH: begin
            w_rd      = ~hold;
            w_last_rd = w_rd && (r_word_idx == IDX_W'(WORDS_PER_BLK - 1));
            if (w_last_rd) begin
               w_state_nxt = DRAIN;
            end
         end
         DRAIN:   w_state_nxt = SWAP;
         SWAP:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_cb_q     <= '0;
         r_word_idx <= '0;
         r_rd_d     <= 1'b0;
         r_pix      <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_rd_d  <= w_rd;
         if (w_accept) begin
            r_cb_q     <= cb_id;
            r_word_idx <= '0;
         end else if (w_rd && !w_last_rd) begin
            // Index parks on the last word; only a new start rewinds it.
            r_word_idx <= r_word_idx + IDX_W'(1);
         end
         if (r_rd_d) begin
            r_pix <= mem_rd_data;
         end
      end
   end

`ifdef CURR_BLK_FEEDER_STALL_CNT_EN
   logic [15:0] r_stall_cnt;

   always_ff @(posedge clk) begin
      if (rst || w_accept) begin
         r_stall_cnt <= '0;
      end else if (r_state == FETCH && hold && r_stall_cnt != 16'hFFFF) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`endif

   // Read data arrives in the enable cycle itself; r_pix keeps the last pair between beats.
   assign current_2pixels = r_rd_d ? mem_rd_data : r_pix;
   assign in_curr_enable  = r_rd_d;
   assign mem_rd_en       = w_rd;
   assign mem_addr        = {r_cb_q, r_word_idx};
   assign CB_select       = r_cb_q;
   assign change_curr     = (r_state == SWAP);
   assign done            = (r_state == SWAP);
   assign busy            = (r_state != IDLE);

endmodule

// File: tb/tb_curr_blk_feeder.sv
// Bench for curr_blk_feeder: buffer model, beat monitor and a cycle-level reference of reads/beats/swap.
module tb_curr_blk_feeder;
   import me_pkg::*;

   logic        clk = 1'b0;
   logic        rst, start, hold;
   logic [2:0]  cb_id;
   logic        mem_rd_en;
   logic [11:0] mem_addr;
   logic [15:0] mem_rd_data = '0;
   logic [15:0] current_2pixels;
   logic        in_curr_enable;
   logic [2:0]  CB_select;
   logic        change_curr, busy, done;
`ifdef CURR_BLK_FEEDER_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   curr_blk_feeder dut (
      .clk(clk), .rst(rst), .start(start), .cb_id(cb_id), .hold(hold),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
      .current_2pixels(current_2pixels), .in_curr_enable(in_curr_enable),
      .CB_select(CB_select), .change_curr(change_curr), .busy(busy),
`ifdef CURR_BLK_FEEDER_STALL_CNT_EN
      .stall_cnt(stall_cnt),
`endif
      .done(done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;
   logic [15:0] salt = '0;
   bit hold_plan [0:2047];

   function automatic logic [15:0] word_of(input logic [11:0] a);
      logic [7:0] lo;
      lo = a[7:0];
      return {lo + 8'd1, lo} ^ salt;
   endfunction

   // Synchronous buffer: data valid the cycle after the read strobe.
   always @(posedge clk) if (mem_rd_en) mem_rd_data <= word_of(mem_addr);

   logic        mon_on = 1'b0;
   int          c0 = 0;
   int          mrel;
   logic [15:0] beat_q[$];
   int          beat_cyc_q[$];
   logic [11:0] addr_q[$];
   int          rd_cyc_q[$];
   int          swap_cyc, n_swap, n_done_mis, n_cbsel_bad, n_busy;
   logic [2:0]  exp_cb;
   logic [15:0] stall_at_done;

   always @(negedge clk) begin
      if (mon_on) begin
         mrel = cyc - c0;
         if (in_curr_enable) begin
            beat_q.push_back(current_2pixels);
            beat_cyc_q.push_back(mrel);
         end
         if (mem_rd_en) begin
            addr_q.push_back(mem_addr);
            rd_cyc_q.push_back(mrel);
         end
         if (change_curr) begin
            n_swap++;
            swap_cyc = mrel;
`ifdef CURR_BLK_FEEDER_STALL_CNT_EN
            stall_at_done = stall_cnt;
`endif
         end
         if (change_curr !== done) n_done_mis++;
         if (busy) begin
            n_busy++;
            if (CB_select !== exp_cb) n_cbsel_bad++;
         end
      end
   end

   task automatic check(input string tag, input longint obs, input longint exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clear_plan();
      for (int i = 0; i < 2048; i++) hold_plan[i] = 1'b0;
   endtask

   // Runs one transfer starting in the current cycle; caller must be positioned just after a clock edge.
   task automatic run_xfer(input logic [2:0] cb, input int inj1, input int inj2,
                           input int rst_at, input int budget, input string nm);
      int rel, stall_exp, bad, tbad, nexp;
      int exp_rd[$];
      beat_q.delete(); beat_cyc_q.delete(); addr_q.delete(); rd_cyc_q.delete();
      n_swap = 0; n_done_mis = 0; n_cbsel_bad = 0; n_busy = 0; swap_cyc = -1;
      exp_cb = cb;
      stall_exp = 0;
      // Reference: a read issues in every cycle from 1 on with hold low, until 512 reads are out.
      for (int r = 1; exp_rd.size() < 512 && r < 2048; r++) begin
         if (!hold_plan[r]) exp_rd.push_back(r);
         else               stall_exp++;
      end
      c0 = cyc; start = 1'b1; cb_id = cb; hold = 1'b0; mon_on = 1'b1;
      forever begin
         @(posedge clk); #1;
         rel = cyc - c0;
         start = 1'b0;
         if (rst_at < 0 && n_swap > 0) break;
         if (rst_at >= 0 && rel == rst_at + 6) break;
         if (rel > budget) begin
            check({nm, " timeout"}, rel, budget);
            break;
         end
         start = (rel == inj1 || rel == inj2);
         cb_id = start ? 3'd2 : 3'($urandom);
         hold  = hold_plan[rel];
         rst   = (rel == rst_at);
         if (rst_at >= 0 && rel == rst_at + 1)
            check({nm, " outputs after rst"},
                  {mem_rd_en, mem_addr, in_curr_enable, current_2pixels, CB_select,
                   change_curr, busy, done}, 0);
      end
      mon_on = 1'b0; start = 1'b0; hold = 1'b0; rst = 1'b0;
      check({nm, " idle after swap"}, busy, 0);

      if (rst_at >= 0) begin
         nexp = 0;
         foreach (exp_rd[i]) if (exp_rd[i] < rst_at) nexp++;
         check({nm, " beats before rst"}, beat_q.size(), nexp);
         check({nm, " swaps"}, n_swap, 0);
         check({nm, " done pulses"}, n_done_mis, 0);
         bad = 0;
         foreach (beat_q[i]) if (beat_q[i] !== word_of({cb, 9'(i)})) bad++;
         check({nm, " data"}, bad, 0);
      end else begin
         check({nm, " beats"}, beat_q.size(), 512);
         check({nm, " reads"}, addr_q.size(), 512);
         bad = 0; tbad = 0;
         foreach (beat_q[i]) begin
            if (beat_q[i] !== word_of({cb, 9'(i)})) bad++;
            if (i < 512 && beat_cyc_q[i] != exp_rd[i] + 1) tbad++;
         end
         check({nm, " data order"}, bad, 0);
         check({nm, " beat timing"}, tbad, 0);
         check({nm, " first beat cycle"}, (beat_cyc_q.size() > 0) ? beat_cyc_q[0] : -1, exp_rd[0] + 1);
         bad = 0; tbad = 0;
         foreach (addr_q[i]) begin
            if (addr_q[i] !== {cb, 9'(i)}) bad++;
            if (i < 512 && rd_cyc_q[i] != exp_rd[i]) tbad++;
         end
         check({nm, " read addresses"}, bad, 0);
         check({nm, " read cycles"}, tbad, 0);
         check({nm, " swap count"}, n_swap, 1);
         check({nm, " swap cycle"}, swap_cyc, exp_rd[511] + 2);
         check({nm, " done vs change_curr"}, n_done_mis, 0);
         check({nm, " CB_select"}, n_cbsel_bad, 0);
         check({nm, " busy cycles"}, n_busy, exp_rd[511] + 2);
`ifdef CURR_BLK_FEEDER_STALL_CNT_EN
         check({nm, " stall_cnt"}, stall_at_done, stall_exp);
`endif
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; hold = 1'b0; cb_id = '0;
      clear_plan();
      repeat (3) @(posedge clk);
      #1;
      check("reset outputs",
            {mem_rd_en, mem_addr, in_curr_enable, current_2pixels, CB_select, change_curr, busy, done}, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Plain transfer; restarts mid-transfer and coincident with done must be ignored.
      run_xfer(3'd5, 100, 514, -1, 1500, "plain");
      repeat (3) @(posedge clk);
      #1;

      salt = 16'($urandom);
      for (int r = 20; r <= 29; r++) hold_plan[r] = 1'b1;
      run_xfer(3'd3, -1, -1, -1, 1500, "hold20_29");
      clear_plan();
      repeat (2) @(posedge clk);
      #1;

      salt = 16'($urandom);
      run_xfer(3'd6, -1, -1, 300, 1500, "reset300");

      salt = 16'($urandom);
      run_xfer(3'($urandom), -1, -1, -1, 1500, "after_reset");

      salt = 16'($urandom);
      for (int r = 1; r < 2048; r++) hold_plan[r] = ($urandom_range(0, 3) == 0);
      run_xfer(3'($urandom), -1, -1, -1, 2000, "back_to_back_rand_hold");
      clear_plan();

      salt = 16'($urandom);
      for (int r = 50; r <= 86; r++) hold_plan[r] = 1'b1;
      run_xfer(3'd7, -1, -1, -1, 1500, "stall37");
      clear_plan();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
